// File: rtl/li_serializer_pkg.sv
// li_pkg: shared definitions for the latency-insensitive (valid/bp) serializer.
//   li_state_e : slot occupancy state (EMPTY/BUSY)
//   clog2      : ceiling log2 for elaboration-time width derivation
//   fire       : handshake transfer condition (valid && !bp)
package li_pkg;

  typedef enum logic {
    EMPTY = 1'b0,
    BUSY  = 1'b1
  } li_state_e;

  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    int unsigned x;
    r = 0;
    x = 1;
    while (x < v) begin
      x = x << 1;
      r = r + 1;
    end
    return r;
  endfunction

  function automatic logic fire(input logic valid, input logic bp);
    return valid & ~bp;
  endfunction

endpackage

// File: rtl/li_serializer_if.sv
// li_serializer_if: wide input channel and narrow output channel of the
// serializer, both using the valid/bp handshake.
//   d/d_valid/d_bp        : wide token in (Ratio*BeatWidth bits)
//   q/q_valid/q_last/q_bp : narrow beat out, q_last marks the final beat
//   slave  : serializer side
//   master : environment side (wide producer + narrow consumer)
interface li_serializer_if #(
  parameter int unsigned BeatWidth = 8,
  parameter int unsigned Ratio     = 4
) ();

  logic [BeatWidth*Ratio-1:0] d;
  logic                       d_valid;
  logic                       d_bp;
  logic [BeatWidth-1:0]       q;
  logic                       q_valid;
  logic                       q_last;
  logic                       q_bp;

  modport slave (
    input  d, d_valid, q_bp,
    output d_bp, q, q_valid, q_last
  );

  modport master (
    output d, d_valid, q_bp,
    input  d_bp, q, q_valid, q_last
  );

endinterface

// File: rtl/li_serializer.sv
// li_serializer: width down-converter for valid/bp channels. Accepts one wide
// token and emits it as Ratio beats, least-significant beat first, flagging
// the final beat with q_last. The next token is accepted on the same edge the
// last beat leaves, so the narrow side runs at full throughput.
//   clk   : rising-edge clock
//   reset : asynchronous, active-high; drops any partially sent token
//   bus   : li_serializer_if.slave (d/d_valid/d_bp in, q/q_valid/q_last/q_bp out)
module li_serializer
  import li_pkg::*;
#(
  parameter int unsigned BeatWidth = 8,
  parameter int unsigned Ratio     = 4
) (
  input  logic              clk,
  input  logic              reset,
  li_serializer_if.slave    bus
);

  localparam int unsigned CountWidth = (clog2(Ratio) > 0) ? clog2(Ratio) : 1;
  localparam logic [CountWidth-1:0] LastIdx = CountWidth'(Ratio - 1);

  li_state_e                  state_q, state_d;
  logic [CountWidth-1:0]      idx_q, idx_d;
  logic [BeatWidth*Ratio-1:0] hold_q, hold_d;

  logic                       full;
  logic                       out_go;
  logic                       last_go;
  logic                       in_go;
  logic                       d_bp;
  logic [BeatWidth-1:0]       q_mux;

  always_comb begin
    full    = (state_q == BUSY);
    out_go  = fire(full, bus.q_bp);
    last_go = out_go && (idx_q == LastIdx);
    // q_bp reaches d_bp combinationally so a waiting token can refill the
    // slot on the very edge the last beat departs.
    d_bp    = full && !last_go;
    in_go   = fire(bus.d_valid, d_bp);

    state_d = state_q;
    idx_d   = idx_q;
    hold_d  = hold_q;
    // in_go is only possible when EMPTY or on last_go, so it covers both the
    // initial load and the bubble-free reload.
    if (in_go) begin
      hold_d  = bus.d;
      idx_d   = '0;
      state_d = BUSY;
    end else if (last_go) begin
      idx_d   = '0;
      state_d = EMPTY;
    end else if (out_go) begin
      idx_d   = idx_q + CountWidth'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= EMPTY;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
    end
  end

  // Data register carries no reset; q is meaningless while q_valid is low.
  always_ff @(posedge clk) begin
    hold_q <= hold_d;
  end

  // Beat select written as a mux over constant part-selects so no index can
  // ever address past the hold register, including the Ratio=1 case.
  always_comb begin
    q_mux = '0;
    for (int unsigned i = 0; i < Ratio; i++) begin
      if (idx_q == CountWidth'(i)) begin
        q_mux = hold_q[i*BeatWidth +: BeatWidth];
      end
    end
  end

  assign bus.d_bp    = d_bp;
  assign bus.q       = q_mux;
  assign bus.q_valid = full;
  assign bus.q_last  = full && (idx_q == LastIdx);

  a_d_stable_under_bp : assert property (
    @(posedge clk) disable iff (reset)
    (bus.d_valid && d_bp) |=> $stable(bus.d)
  );

  a_idx_in_range : assert property (
    @(posedge clk) disable iff (reset)
    idx_q <= LastIdx
  );

endmodule

// File: tb/tb_li_serializer.sv
module tb_li_serializer;

  typedef struct packed {
    logic [7:0] data;
    logic       last;
  } beat_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int          checks   = 0;
  int          failures = 0;
  int unsigned cyc      = 0;

  beat_t       qa[$];
  beat_t       qb[$];
  beat_t       qc[$];
  bit          contig_en[3];
  bit          seen[3];
  int unsigned last_cyc[3];
  bit          hit;

  li_serializer_if #(.BeatWidth(8), .Ratio(4)) ifa ();
  li_serializer_if #(.BeatWidth(4), .Ratio(3)) ifb ();
  li_serializer_if #(.BeatWidth(8), .Ratio(1)) ifc ();

  li_serializer #(.BeatWidth(8), .Ratio(4)) dut_a (.clk(clk), .reset(rst), .bus(ifa.slave));
  li_serializer #(.BeatWidth(4), .Ratio(3)) dut_b (.clk(clk), .reset(rst), .bus(ifb.slave));
  li_serializer #(.BeatWidth(8), .Ratio(1)) dut_c (.clk(clk), .reset(rst), .bus(ifc.slave));

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic int qsize(input int w);
    case (w)
      0:       return qa.size();
      1:       return qb.size();
      default: return qc.size();
    endcase
  endfunction

  function automatic logic dbp(input int w);
    case (w)
      0:       return ifa.d_bp;
      1:       return ifb.d_bp;
      default: return ifc.d_bp;
    endcase
  endfunction

  function automatic logic qv(input int w);
    case (w)
      0:       return ifa.q_valid;
      1:       return ifb.q_valid;
      default: return ifc.q_valid;
    endcase
  endfunction

  task automatic push_token(input int w, input logic [31:0] tok);
    case (w)
      0: for (int i = 0; i < 4; i++) qa.push_back(beat_t'{tok[i*8 +: 8], (i == 3)});
      1: for (int i = 0; i < 3; i++) qb.push_back(beat_t'{{4'h0, tok[i*4 +: 4]}, (i == 2)});
      default: qc.push_back(beat_t'{tok[7:0], 1'b1});
    endcase
  endtask

  // Compare one transferred beat against the head of that DUT's scoreboard.
  task automatic score(input int w, input logic [7:0] got, input logic got_last,
                       input logic got_dbp);
    beat_t e;
    int    sz;
    sz = qsize(w);
    check_eq("beat_expected", (sz != 0), 1);
    if (sz == 0) return;
    case (w)
      0:       e = qa.pop_front();
      1:       e = qb.pop_front();
      default: e = qc.pop_front();
    endcase
    check_eq("beat_data", got, e.data);
    check_eq("beat_last", got_last, e.last);
    // On a transferring beat the slot frees exactly when it is the last one.
    check_eq("d_bp_on_xfer", got_dbp, !e.last);
    if (contig_en[w]) begin
      if (seen[w]) check_eq("beat_gap", cyc - last_cyc[w], 1);
      seen[w]     = 1'b1;
      last_cyc[w] = cyc;
    end
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (ifa.q_valid && !ifa.q_bp) score(0, ifa.q, ifa.q_last, ifa.d_bp);
      if (ifb.q_valid && !ifb.q_bp) score(1, {4'h0, ifb.q}, ifb.q_last, ifb.d_bp);
      if (ifc.q_valid && !ifc.q_bp) score(2, ifc.q, ifc.q_last, ifc.d_bp);
    end
  end

  task automatic send(input int w, input logic [31:0] tok);
    bit ok;
    ok = 1'b0;
    case (w)
      0: begin ifa.d = tok;        ifa.d_valid = 1'b1; end
      1: begin ifb.d = tok[11:0];  ifb.d_valid = 1'b1; end
      default: begin ifc.d = tok[7:0]; ifc.d_valid = 1'b1; end
    endcase
    for (int n = 0; n < 64 && !ok; n++) begin
      @(negedge clk);
      if (!rst && !dbp(w)) begin
        push_token(w, tok);
        ok = 1'b1;
      end
    end
    @(posedge clk);
    #1;
    case (w)
      0:       ifa.d_valid = 1'b0;
      1:       ifb.d_valid = 1'b0;
      default: ifc.d_valid = 1'b0;
    endcase
    check_eq("accept_in_time", ok, 1);
  endtask

  task automatic wait_drain(input int w);
    for (int n = 0; n < 100 && qsize(w) != 0; n++) @(negedge clk);
    @(posedge clk);
    #1;
    check_eq("drained", qsize(w), 0);
    check_eq("idle_after_drain", qv(w), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    ifa.d = '0; ifa.d_valid = 1'b0; ifa.q_bp = 1'b0;
    ifb.d = '0; ifb.d_valid = 1'b0; ifb.q_bp = 1'b0;
    ifc.d = '0; ifc.d_valid = 1'b0; ifc.q_bp = 1'b0;

    // Reset state
    #12;
    check_eq("rst_q_valid", ifa.q_valid, 0);
    check_eq("rst_q_last", ifa.q_last, 0);
    check_eq("rst_d_bp", ifa.d_bp, 0);
    check_eq("rst_b_q_valid", ifb.q_valid, 0);
    check_eq("rst_c_q_valid", ifc.q_valid, 0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Single token, first beat one cycle after accept
    send(0, 32'hDDCCBBAA);
    check_eq("t1_first_beat", ifa.q, 8'hAA);
    check_eq("t1_first_valid", ifa.q_valid, 1);
    repeat (4) @(posedge clk);
    #1;
    check_eq("t1_idle", ifa.q_valid, 0);

    // Back-to-back tokens, no bubble
    contig_en[0] = 1'b1;
    seen[0]      = 1'b0;
    send(0, 32'h03020100);
    send(0, 32'h07060504);
    wait_drain(0);
    contig_en[0] = 1'b0;

    // Consumer stall on beat 22
    send(0, 32'h44332211);
    @(posedge clk);
    #1;
    ifa.q_bp = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check_eq("t3_stall_q", ifa.q, 8'h22);
      check_eq("t3_stall_valid", ifa.q_valid, 1);
      check_eq("t3_stall_dbp", ifa.d_bp, 1);
      @(posedge clk);
      #1;
    end
    ifa.q_bp = 1'b0;
    wait_drain(0);

    // Stall on the last beat while the next token waits
    hit = 1'b0;
    fork
      begin
        send(0, 32'hA3A2A1A0);
        send(0, 32'hB3B2B1B0);
      end
      begin
        for (int n = 0; n < 40 && !hit; n++) begin
          @(posedge clk);
          #1;
          if (ifa.q_last) hit = 1'b1;
        end
        check_eq("t4_last_seen", hit, 1);
        ifa.q_bp = 1'b1;
        repeat (2) begin
          @(negedge clk);
          check_eq("t4_dbp_held", ifa.d_bp, 1);
          check_eq("t4_last_q", ifa.q, 8'hA3);
          @(posedge clk);
          #1;
        end
        ifa.q_bp = 1'b0;
        @(negedge clk);
        check_eq("t4_dbp_release", ifa.d_bp, 0);
        @(posedge clk);
        #1;
        check_eq("t4_next_first", ifa.q, 8'hB0);
        check_eq("t4_next_valid", ifa.q_valid, 1);
      end
    join
    wait_drain(0);

    // Asynchronous reset mid-token after beat BB
    send(0, 32'hDDCCBBAA);
    @(posedge clk);
    #1;
    @(posedge clk);
    #2;
    check_eq("t5_pre_rst_q", ifa.q, 8'hCC);
    rst = 1'b1;
    #1;
    check_eq("t5_async_q_valid", ifa.q_valid, 0);
    check_eq("t5_async_d_bp", ifa.d_bp, 0);
    check_eq("t5_async_q_last", ifa.q_last, 0);
    qa.delete();
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    check_eq("t5_no_partial", ifa.q_valid, 0);
    send(0, 32'h0F0E0D0C);
    check_eq("t5_restart_beat0", ifa.q, 8'h0C);
    wait_drain(0);

    // Ratio=3, BeatWidth=4
    send(1, 32'h00000CBA);
    wait_drain(1);

    // Ratio=1 stream of five tokens
    contig_en[2] = 1'b1;
    seen[2]      = 1'b0;
    for (int i = 0; i < 5; i++) send(2, 32'h50 + i);
    wait_drain(2);
    contig_en[2] = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
